// File: rtl/wave_draw_ctrl_pkg.sv
// Shared types, defaults and helpers for the waveform column sequencer.
package wave_pkg;

  localparam int unsigned N_SAMPLES_DEF = 300;
  localparam logic [7:0]  OUT_CODE_DEF  = 8'hFF;
  localparam int unsigned ADDR_W        = 9;
  localparam int unsigned Y_W           = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    EMIT,
    DONE
  } state_t;

  // One vertical column segment handed to the pixel writer.
  typedef struct packed {
    logic [ADDR_W-1:0] x;
    logic [Y_W-1:0]    y_top;
    logic [Y_W-1:0]    y_bot;
    logic              blank;
  } col_seg_t;

  function automatic logic [Y_W-1:0] y_min(input logic [Y_W-1:0] a, input logic [Y_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [Y_W-1:0] y_max(input logic [Y_W-1:0] a, input logic [Y_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wave_draw_ctrl_if.sv
// Sample-read and column-output channels of the waveform sequencer.
interface wave_draw_ctrl_if;
  import wave_pkg::*;

  logic [ADDR_W-1:0] rd_rom_addr;
  logic              lcd_data_req;
  logic [Y_W-1:0]    rd_ad_data;
  logic              col_valid;
  logic              col_ready;
  logic [ADDR_W-1:0] col_x;
  logic [Y_W-1:0]    col_y_top;
  logic [Y_W-1:0]    col_y_bot;
  logic              col_blank;

  modport master (
    output rd_rom_addr, lcd_data_req,
    input  rd_ad_data,
    output col_valid, col_x, col_y_top, col_y_bot, col_blank,
    input  col_ready
  );

  modport slave (
    input  rd_rom_addr, lcd_data_req,
    output rd_ad_data,
    input  col_valid, col_x, col_y_top, col_y_bot, col_blank,
    output col_ready
  );

endinterface

// File: rtl/wave_draw_ctrl_sync_2ff.sv
// Single-bit two-flop synchronizer into the destination clock domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/wave_draw_ctrl.sv
// Per-frame sequencer: reads the capture buffer and emits one column segment per sample.
// Optional peak tracking outputs are built when WAVE_PEAK_EN is defined.
module wave_draw_ctrl
  import wave_pkg::*;
#(
  parameter int unsigned N_SAMPLES = N_SAMPLES_DEF,
  parameter int unsigned RD_LAT    = 2,
  parameter logic [7:0]  OUT_CODE  = OUT_CODE_DEF
) (
  input  logic              lcd_clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              cap_done,
  input  logic              wave_run,
  wave_draw_ctrl_if.master  bus,
  output logic              lcd_wr_over,
  output logic              busy
`ifdef WAVE_PEAK_EN
  ,
  output logic [Y_W-1:0]    wave_max,
  output logic [Y_W-1:0]    wave_min,
  output logic              peak_valid
`endif
);

  localparam int unsigned      WCNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_SAMPLES - 1);

  logic cap_done_s;
  logic run_s;

  sync_2ff u_sync_cap (.clk(lcd_clk), .rst_n(rst_n), .d(cap_done), .q(cap_done_s));
  sync_2ff u_sync_run (.clk(lcd_clk), .rst_n(rst_n), .d(wave_run), .q(run_s));

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [Y_W-1:0]    cur_q, cur_d;
  logic [Y_W-1:0]    prev_q, prev_d;
  col_seg_t          seg_q, seg_d;
  logic              col_valid_q, col_valid_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_over_q, wr_over_d;
  logic              busy_q, busy_d;
  logic [Y_W-1:0]    rd_y;

  assign rd_y = bus.rd_ad_data;

`ifdef WAVE_PEAK_EN
  logic [Y_W-1:0] run_max_q, run_max_d;
  logic [Y_W-1:0] run_min_q, run_min_d;
  logic           any_q, any_d;
  logic [Y_W-1:0] wave_max_q, wave_max_d;
  logic [Y_W-1:0] wave_min_q, wave_min_d;
  logic           peak_valid_q, peak_valid_d;
`endif

  // State and datapath registers; every output comes straight from a flop.
  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wcnt_q      <= '0;
      cur_q       <= '0;
      prev_q      <= '0;
      seg_q       <= '0;
      col_valid_q <= 1'b0;
      req_q       <= 1'b0;
      rd_addr_q   <= '0;
      wr_over_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef WAVE_PEAK_EN
      run_max_q    <= '0;
      run_min_q    <= '1;
      any_q        <= 1'b0;
      wave_max_q   <= '0;
      wave_min_q   <= '0;
      peak_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wcnt_q      <= wcnt_d;
      cur_q       <= cur_d;
      prev_q      <= prev_d;
      seg_q       <= seg_d;
      col_valid_q <= col_valid_d;
      req_q       <= req_d;
      rd_addr_q   <= rd_addr_d;
      wr_over_q   <= wr_over_d;
      busy_q      <= busy_d;
`ifdef WAVE_PEAK_EN
      run_max_q    <= run_max_d;
      run_min_q    <= run_min_d;
      any_q        <= any_d;
      wave_max_q   <= wave_max_d;
      wave_min_q   <= wave_min_d;
      peak_valid_q <= peak_valid_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wcnt_d      = wcnt_q;
    cur_d       = cur_q;
    prev_d      = prev_q;
    seg_d       = seg_q;
    col_valid_d = col_valid_q;
    req_d       = 1'b0;
    rd_addr_d   = rd_addr_q;
    wr_over_d   = wr_over_q;
    busy_d      = busy_q;
`ifdef WAVE_PEAK_EN
    run_max_d    = run_max_q;
    run_min_d    = run_min_q;
    any_d        = any_q;
    wave_max_d   = wave_max_q;
    wave_min_d   = wave_min_q;
    peak_valid_d = peak_valid_q;
`endif

    unique case (state_q)
      IDLE: begin
        // Skipped frames keep the previous image on screen.
        if (frame_start && (cap_done_s || !run_s)) begin
          state_d   = ISSUE;
          addr_d    = '0;
          rd_addr_d = '0;
          req_d     = 1'b1;
          busy_d    = 1'b1;
`ifdef WAVE_PEAK_EN
          run_max_d = '0;
          run_min_d = '1;
          any_d     = 1'b0;
`endif
        end
      end

      ISSUE: begin
        state_d = WAIT;
        wcnt_d  = '0;
      end

      WAIT: begin
        if (wcnt_q == WCNT_LAST) begin
          cur_d       = rd_y;
          state_d     = EMIT;
          col_valid_d = 1'b1;
          seg_d.x     = addr_q;
          if (addr_q == '0) begin
            seg_d.y_top = rd_y;
            seg_d.y_bot = rd_y;
            seg_d.blank = (rd_y == OUT_CODE);
          end else begin
            seg_d.y_top = y_min(prev_q, rd_y);
            seg_d.y_bot = y_max(prev_q, rd_y);
            seg_d.blank = (rd_y == OUT_CODE) || (prev_q == OUT_CODE);
          end
`ifdef WAVE_PEAK_EN
          if (rd_y != OUT_CODE) begin
            run_max_d = y_max(run_max_q, rd_y);
            run_min_d = y_min(run_min_q, rd_y);
            any_d     = 1'b1;
          end
`endif
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end

      EMIT: begin
        if (bus.col_ready) begin
          col_valid_d = 1'b0;
          prev_d      = cur_q;
          if (addr_q == ADDR_LAST) begin
            state_d   = DONE;
            busy_d    = 1'b0;
            wr_over_d = run_s;
`ifdef WAVE_PEAK_EN
            wave_max_d   = any_q ? run_max_q : '0;
            wave_min_d   = any_q ? run_min_q : '0;
            peak_valid_d = any_q;
`endif
          end else begin
            addr_d    = addr_q + ADDR_W'(1);
            rd_addr_d = addr_q + ADDR_W'(1);
            req_d     = 1'b1;
            state_d   = ISSUE;
          end
        end
      end

      DONE: begin
        // Four-phase return: hold until capture side drops cap_done, or freeze aborts it.
        if (!run_s || !cap_done_s) begin
          wr_over_d = 1'b0;
          state_d   = IDLE;
        end else begin
          wr_over_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.rd_rom_addr  = rd_addr_q;
  assign bus.lcd_data_req = req_q;
  assign bus.col_valid    = col_valid_q;
  assign bus.col_x        = seg_q.x;
  assign bus.col_y_top    = seg_q.y_top;
  assign bus.col_y_bot    = seg_q.y_bot;
  assign bus.col_blank    = seg_q.blank;
  assign lcd_wr_over      = wr_over_q;
  assign busy             = busy_q;

`ifdef WAVE_PEAK_EN
  assign wave_max   = wave_max_q;
  assign wave_min   = wave_min_q;
  assign peak_valid = peak_valid_q;
`endif

endmodule

// File: tb/tb_wave_draw_ctrl.sv
// Scoreboard bench for wave_draw_ctrl: stimulus queues expected columns, a monitor pops on handshake.
module tb_wave_draw_ctrl;
  import wave_pkg::*;

  localparam int unsigned N = 300;

  logic lcd_clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic cap_done = 1'b0;
  logic wave_run = 1'b0;
  logic lcd_wr_over;
  logic busy;
`ifdef WAVE_PEAK_EN
  logic [7:0] wave_max;
  logic [7:0] wave_min;
  logic       peak_valid;
`endif

  wave_draw_ctrl_if bus();

  wave_draw_ctrl #(.N_SAMPLES(N), .RD_LAT(2), .OUT_CODE(8'hFF)) dut (
    .lcd_clk    (lcd_clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .cap_done   (cap_done),
    .wave_run   (wave_run),
    .bus        (bus),
    .lcd_wr_over(lcd_wr_over),
    .busy       (busy)
`ifdef WAVE_PEAK_EN
    ,
    .wave_max   (wave_max),
    .wave_min   (wave_min),
    .peak_valid (peak_valid)
`endif
  );

  always #5 lcd_clk = ~lcd_clk;

  // Capture buffer model: data valid two cycles after the read request.
  logic [7:0] mem [N];
  logic [7:0] rom_s1 = 8'd0;
  always @(posedge lcd_clk) begin
    if (bus.lcd_data_req) rom_s1 <= mem[bus.rd_rom_addr];
    bus.rd_ad_data <= rom_s1;
  end

  int checks = 0;
  int failures = 0;
  col_seg_t exp_q[$];
  bit chk_ramp = 1'b0;
  bit chk_oor = 1'b0;
  bit chk_freeze = 1'b0;
  int wr_over_seen = 0;
  int last_x = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    col_seg_t e;
    logic [25:0] held;
    bit stall_prev;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge lcd_clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_stable", 32'({bus.col_x, bus.col_y_top, bus.col_y_bot, bus.col_blank}), 32'(held));
          check("stall_no_req", 32'(bus.lcd_data_req), 32'd0);
        end
        if (bus.col_valid && bus.col_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_col", 32'(bus.col_x), 32'hFFFF);
          end else begin
            e = exp_q.pop_front();
            check("col_x", 32'(bus.col_x), 32'(e.x));
            check("col_y_top", 32'(bus.col_y_top), 32'(e.y_top));
            check("col_y_bot", 32'(bus.col_y_bot), 32'(e.y_bot));
            check("col_blank", 32'(bus.col_blank), 32'(e.blank));
            if (chk_ramp && bus.col_x == 9'd5) begin
              check("col5_top", 32'(bus.col_y_top), 32'd4);
              check("col5_bot", 32'(bus.col_y_bot), 32'd5);
            end
            if (chk_oor && (bus.col_x == 9'd9 || bus.col_x == 9'd22))
              check("oor_edge_blank", 32'(bus.col_blank), 32'd0);
            if (chk_oor && (bus.col_x == 9'd10 || bus.col_x == 9'd21))
              check("oor_in_blank", 32'(bus.col_blank), 32'd1);
            last_x = int'(bus.col_x);
          end
        end
        stall_prev = bus.col_valid && !bus.col_ready;
        held = {bus.col_x, bus.col_y_top, bus.col_y_bot, bus.col_blank};
        if (chk_freeze && lcd_wr_over) wr_over_seen++;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge lcd_clk);
    #1;
  endtask

  task automatic pulse_frame();
    @(posedge lcd_clk); #1 frame_start = 1'b1;
    @(posedge lcd_clk); #1 frame_start = 1'b0;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < int'(N); i++) mem[i] = 8'(i);
  endtask

  task automatic push_pass();
    col_seg_t e;
    logic [7:0] c;
    logic [7:0] p;
    for (int i = 0; i < int'(N); i++) begin
      c = mem[i];
      p = (i == 0) ? c : mem[i-1];
      e.x = 9'(i);
      e.y_top = (c < p) ? c : p;
      e.y_bot = (c < p) ? p : c;
      e.blank = (c == 8'hFF) || (i != 0 && p == 8'hFF);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_wr_over(input string name, input int budget, output int cyc);
    cyc = 0;
    while (lcd_wr_over !== 1'b1 && cyc < budget) begin
      tick(1);
      cyc++;
    end
    if (cyc >= budget) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    int cyc;
    bit seen;
    bit stalled;
    bus.col_ready = 1'b1;
    load_ramp();
    fork
      monitor();
    join_none

    // Reset state
    tick(3);
    check("reset_outputs", 32'(|{bus.rd_rom_addr, bus.lcd_data_req, bus.col_valid, bus.col_x,
          bus.col_y_top, bus.col_y_bot, bus.col_blank, lcd_wr_over, busy}), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Basic pass with ramp
    wave_run = 1'b1;
    cap_done = 1'b1;
    tick(4);
    chk_ramp = 1'b1;
    push_pass();
    pulse_frame();
    wait_wr_over("basic", 2000, cyc);
    check("basic_cycles", 32'(cyc), 32'd1200);
    check("basic_last_x", 32'(last_x), 32'd299);
    check("basic_queue_empty", 32'(exp_q.size()), 32'd0);
    check("basic_busy_done", 32'(busy), 32'd0);
`ifdef WAVE_PEAK_EN
    check("peak_valid", 32'(peak_valid), 32'd1);
    check("peak_max", 32'(wave_max), 32'd254);
    check("peak_min", 32'(wave_min), 32'd0);
`endif
    chk_ramp = 1'b0;
    tick(5);
    check("wr_over_held", 32'(lcd_wr_over), 32'd1);
    cap_done = 1'b0;
    tick(3);
    check("wr_over_release", 32'(lcd_wr_over), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Skip frame: running with no capture ready
    tick(4);
    seen = 1'b0;
    pulse_frame();
    for (int i = 0; i < 20; i++) begin
      if (bus.lcd_data_req || busy) seen = 1'b1;
      tick(1);
    end
    check("skip_no_activity", 32'(seen), 32'd0);

    // Backpressure at column 7 and out-of-range samples 10..20
    for (int i = 10; i <= 20; i++) mem[i] = 8'hFF;
    cap_done = 1'b1;
    tick(4);
    chk_oor = 1'b1;
    push_pass();
    pulse_frame();
    stalled = 1'b0;
    cyc = 0;
    while (lcd_wr_over !== 1'b1 && cyc < 3000) begin
      if (!stalled && bus.col_valid && bus.col_x == 9'd7) begin
        bus.col_ready = 1'b0;
        tick(10);
        bus.col_ready = 1'b1;
        stalled = 1'b1;
      end else begin
        tick(1);
        cyc++;
      end
    end
    if (cyc >= 3000) check("bp_timeout", 32'd1, 32'd0);
    check("bp_stall_hit", 32'(stalled), 32'd1);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    chk_oor = 1'b0;
    cap_done = 1'b0;
    tick(3);
    check("bp_wr_over_release", 32'(lcd_wr_over), 32'd0);
    load_ramp();

    // Freeze: two full redraws without handshake
    wave_run = 1'b0;
    tick(4);
    chk_freeze = 1'b1;
    wr_over_seen = 0;
    for (int p = 0; p < 2; p++) begin
      push_pass();
      pulse_frame();
      cyc = 0;
      while ((exp_q.size() != 0 || busy) && cyc < 1500) begin
        tick(1);
        cyc++;
      end
      if (cyc >= 1500) check("freeze_timeout", 32'd1, 32'd0);
      check("freeze_last_x", 32'(last_x), 32'd299);
      tick(2);
    end
    check("freeze_no_wr_over", 32'(wr_over_seen), 32'd0);
    chk_freeze = 1'b0;

    // Reset mid-pass at column 150
    wave_run = 1'b1;
    cap_done = 1'b1;
    tick(4);
    push_pass();
    pulse_frame();
    cyc = 0;
    while (!(bus.col_valid && bus.col_x == 9'd150) && cyc < 1000) begin
      tick(1);
      cyc++;
    end
    if (cyc >= 1000) check("mid_reset_timeout", 32'd1, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", 32'(|{bus.rd_rom_addr, bus.lcd_data_req, bus.col_valid, bus.col_x,
          bus.col_y_top, bus.col_y_bot, bus.col_blank, lcd_wr_over, busy}), 32'd0);
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(4);
    check("no_restart_without_frame", 32'(busy), 32'd0);
    last_x = -1;
    push_pass();
    pulse_frame();
    wait_wr_over("restart", 1400, cyc);
    check("restart_cycles", 32'(cyc), 32'd1200);
    check("restart_queue_empty", 32'(exp_q.size()), 32'd0);
    cap_done = 1'b0;
    tick(3);
    check("restart_wr_over_release", 32'(lcd_wr_over), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wave_draw_ctrl.md
Name: wave_draw_ctrl

Overview:
- lcd_clk-domain sequencer for the oscilloscope waveform capture buffer.
- Once per LCD frame it reads the 300 stored samples in order by driving rd_rom_addr and lcd_data_req.
- Converts each sample pair into a vertical column segment for the downstream pixel writer, which it feeds through a valid/ready handshake.
- Returns lcd_wr_over to the ad_clk capture side as a 4-phase handshake so the next capture can re-arm.

Parameters:
- N_SAMPLES, 300, samples per trace; also the number of columns per pass.
- RD_LAT, 2, lcd_clk cycles from rd_rom_addr/lcd_data_req to valid rd_ad_data.
- OUT_CODE, 8'd255, rd_ad_data value meaning "outside display range".

Ports:
- lcd_clk, in, 1, display clock.
- rst_n, in, 1, asynchronous active-low reset.
- frame_start, in, 1, one-cycle pulse at LCD frame start.
- cap_done, in, 1, level from ad_clk domain: capture complete. Asynchronous to lcd_clk.
- wave_run, in, 1, run(1)/freeze(0). Quasi-static, asynchronous to lcd_clk.
- rd_rom_addr, out, 9, sample read address.
- lcd_data_req, out, 1, read enable.
- rd_ad_data, in, 8, sample (screen y), or OUT_CODE.
- col_valid, out, 1, column segment valid.
- col_ready, in, 1, downstream accepts the column.
- col_x, out, 9, column index 0..N_SAMPLES-1.
- col_y_top, out, 8, smaller y of the segment.
- col_y_bot, out, 8, larger y of the segment.
- col_blank, out, 1, column must not be drawn.
- lcd_wr_over, out, 1, level: trace drawn (handshake to capture side).
- busy, out, 1, pass in progress.

Behaviour:
- Synchronizers: cap_done and wave_run each pass through a 2-flop synchronizer; the FSM uses only cap_done_s and run_s.
- Reset values: every output is 0; FSM is in IDLE; prev_y = 0.
- Reset is honoured at any time, including mid-pass: the pass is abandoned with no completion pulse, and a new pass starts only at the next qualifying frame_start.
- FSM states: IDLE, ISSUE, WAIT, EMIT, DONE.
- IDLE:
  - On frame_start with (cap_done_s || !run_s): go to ISSUE, set addr=0, busy=1.
  - Otherwise stay in IDLE; the frame is skipped and the prior image is kept.
  - frame_start outside IDLE is ignored.
- ISSUE: drive rd_rom_addr=addr and lcd_data_req=1 for exactly one cycle; go to WAIT.
- WAIT: count RD_LAT-1 further cycles, then latch cur=rd_ad_data on the last cycle; go to EMIT.
- EMIT:
  - Drive col_valid=1 and col_x=addr.
  - col_y_top = min(prev_y, cur) and col_y_bot = max(prev_y, cur); for addr 0 both equal cur.
  - col_blank = (cur==OUT_CODE) || (addr!=0 && prev_y==OUT_CODE).
  - All col_* outputs hold stable while col_valid && !col_ready.
  - On col_ready: prev_y<=cur and col_valid drops.
    - If addr==N_SAMPLES-1, go to DONE.
    - Else addr<=addr+1 and go to ISSUE.
- DONE:
  - busy=0.
  - If run_s: hold lcd_wr_over=1 until cap_done_s==0, then lcd_wr_over=0 and go to IDLE.
  - If !run_s: no handshake; lcd_wr_over stays 0 and the FSM goes to IDLE the next cycle. In freeze mode the frozen buffer is redrawn every frame.
  - run_s falling while waiting in DONE: release lcd_wr_over and go to IDLE.
- Throughput: RD_LAT+2 cycles per column when col_ready=1 (1 ISSUE cycle, RD_LAT-1 WAIT cycles, 1 latch cycle, 1 EMIT cycle); 1200 cycles per pass at RD_LAT=2.
- Width rules: addr is 9-bit and never exceeds N_SAMPLES-1. min/max is an unsigned 8-bit compare.

Optional Feature:
- Macro: WAVE_PEAK_EN.
- When defined:
  - Adds outputs wave_max[7:0] and wave_min[7:0] (screen-y extremes of the in-range samples) and peak_valid.
  - Running extremes are updated on every in-range latched cur.
  - At the DONE entry they are copied to the outputs and peak_valid is set.
  - If all samples are OUT_CODE, peak_valid=0.
  - Outputs reset to 0.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package wave_pkg holds:
  - FSM state encoding,
  - N_SAMPLES_DEF=300,
  - OUT_CODE_DEF=8'hFF,
  - the min/max helper function.
- One sub-module, sync_2ff (single-bit 2-flop synchronizer), instantiated twice.

Test Plan:
- Basic pass:
  - Stimulus: wave_run=1, cap_done=1, frame_start, buffer ramp y=addr[7:0], col_ready=1.
  - Required: 300 columns, col_x 0..299; column 5 has top=4, bot=5; lcd_wr_over rises after col_x=299.
  - Then drop cap_done: lcd_wr_over falls within 3 cycles and the FSM is back in IDLE.
- Skip frame: wave_run=1, cap_done=0, frame_start -> no lcd_data_req, busy stays 0.
- Backpressure:
  - Stimulus: hold col_ready=0 for 10 cycles at col_x=7.
  - Required: col_x/col_y_top/col_y_bot stable throughout, no new lcd_data_req until acceptance.
- Out of range:
  - Stimulus: samples 10..20 = 255.
  - Required: columns 10..21 have col_blank=1; column 9 and column 22 have col_blank=0.
- Freeze: wave_run=0, cap_done=0, two frame_starts -> two full passes, lcd_wr_over never asserted.
- Reset mid-pass: rst_n low at col_x=150 -> all outputs 0 immediately; the next frame_start restarts at col_x=0.
